// File: rtl/audio_frame_sequencer.sv
// Moves samples from the ADC FIFO to the DAC FIFO, with optional square-wave muting,
// and captures fixed-length mono frames for the recognizer. Optional: AUDIO_SEQ_PEAK_EN.
module audio_frame_sequencer #(
    parameter int FRAME_LEN = 256,
    parameter int ADDR_W    = 8,
    parameter int STALL_MAX = 1024
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              audio_in_available,
    input  logic [31:0]       left_channel_audio_in,
    input  logic [31:0]       right_channel_audio_in,
    output logic              read_audio_in,
    input  logic              audio_out_allowed,
    output logic [31:0]       left_channel_audio_out,
    output logic [31:0]       right_channel_audio_out,
    output logic              write_audio_out,
    input  logic [17:0]       gate_period,
    input  logic              capture_start,
    output logic              capture_busy,
    output logic              capture_done,
    output logic              frame_wr_en,
    output logic [ADDR_W-1:0] frame_wr_addr,
    output logic [15:0]       frame_wr_data,
    output logic [7:0]        drop_count
`ifdef AUDIO_SEQ_PEAK_EN
    ,
    output logic [15:0]       peak_level
`endif
);

    typedef enum logic [1:0] {POLL, XFER, DROP, GAP} state_t;

    localparam int SW = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;
    localparam logic [SW-1:0]     STALL_LAST = SW'(STALL_MAX - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(FRAME_LEN - 1);

    // Mono mix: 17-bit sum of the two upper halves, arithmetic halving.
    function automatic logic [15:0] mono16(input logic [15:0] l, input logic [15:0] r);
        logic signed [16:0] sum;
        sum = $signed({l[15], l}) + $signed({r[15], r});
        return sum[16:1];
    endfunction

`ifdef AUDIO_SEQ_PEAK_EN
    function automatic logic [15:0] abs16(input logic [15:0] v);
        if (v == 16'h8000)
            return 16'h7FFF;
        else if (v[15])
            return 16'(-v);
        else
            return v;
    endfunction

    logic [15:0] peak_q;
`endif

    state_t            state_q, state_d;
    logic [SW-1:0]     stall_q, stall_d;
    logic [17:0]       gate_cnt_q, gate_cnt_d;
    logic              mute_q, mute_d;
    logic              accept, drop_go;

    logic [15:0]       lat_l_q, lat_r_q;
    logic              read_q, write_q;
    logic [31:0]       dac_l_q, dac_r_q;
    logic [7:0]        drop_q;
    logic              busy_q, last_q, done_q, fwe_q;
    logic [ADDR_W-1:0] addr_q, fwaddr_q;
    logic [15:0]       fwdata_q;

    always_comb begin
        state_d    = state_q;
        stall_d    = stall_q;
        accept     = 1'b0;
        drop_go    = 1'b0;
        gate_cnt_d = gate_cnt_q;
        mute_d     = mute_q;

        case (state_q)
            POLL: begin
                if (audio_in_available && audio_out_allowed) begin
                    accept  = 1'b1;
                    stall_d = '0;
                    state_d = XFER;
                end else if (audio_in_available) begin
                    if (stall_q == STALL_LAST) begin
                        drop_go = 1'b1;
                        stall_d = '0;
                        state_d = DROP;
                    end else begin
                        stall_d = stall_q + SW'(1);
                    end
                end else begin
                    stall_d = '0;
                end
            end
            XFER:    state_d = GAP;
            DROP: begin
                stall_d = '0;
                state_d = GAP;
            end
            GAP:     state_d = POLL;
            default: state_d = POLL;
        endcase

        // A period shrunk below the running count wraps on the next cycle.
        if (gate_period == 18'd0) begin
            gate_cnt_d = '0;
            mute_d     = 1'b0;
        end else if (gate_cnt_q >= gate_period) begin
            gate_cnt_d = '0;
            mute_d     = ~mute_q;
        end else begin
            gate_cnt_d = gate_cnt_q + 18'd1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= POLL;
            stall_q    <= '0;
            gate_cnt_q <= '0;
            mute_q     <= 1'b0;
            lat_l_q    <= '0;
            lat_r_q    <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            dac_l_q    <= '0;
            dac_r_q    <= '0;
            drop_q     <= '0;
            busy_q     <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            fwe_q      <= 1'b0;
            addr_q     <= '0;
            fwaddr_q   <= '0;
            fwdata_q   <= '0;
`ifdef AUDIO_SEQ_PEAK_EN
            peak_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            stall_q    <= stall_d;
            gate_cnt_q <= gate_cnt_d;
            mute_q     <= mute_d;

            // Pulses are registered so they coincide with the XFER/DROP state cycle.
            read_q  <= accept | drop_go;
            write_q <= accept;
            if (accept) begin
                dac_l_q <= mute_q ? 32'd0 : left_channel_audio_in;
                dac_r_q <= mute_q ? 32'd0 : right_channel_audio_in;
                lat_l_q <= left_channel_audio_in[31:16];
                lat_r_q <= right_channel_audio_in[31:16];
            end
            if (drop_go && drop_q != 8'hFF)
                drop_q <= drop_q + 8'd1;

            fwe_q  <= 1'b0;
            done_q <= 1'b0;
            last_q <= 1'b0;
            if (state_q == XFER && busy_q) begin
                fwe_q    <= 1'b1;
                fwaddr_q <= addr_q;
                fwdata_q <= mono16(lat_l_q, lat_r_q);
`ifdef AUDIO_SEQ_PEAK_EN
                if (abs16(lat_l_q) > peak_q)
                    peak_q <= abs16(lat_l_q);
`endif
                if (addr_q == ADDR_LAST) begin
                    last_q <= 1'b1;
                    addr_q <= '0;
                end else begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
            end
            if (last_q) begin
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                fwaddr_q <= '0;
            end
            if (capture_start && !busy_q) begin
                busy_q <= 1'b1;
                addr_q <= '0;
`ifdef AUDIO_SEQ_PEAK_EN
                peak_q <= '0;
`endif
            end
        end
    end

    assign read_audio_in           = read_q;
    assign write_audio_out         = write_q;
    assign left_channel_audio_out  = dac_l_q;
    assign right_channel_audio_out = dac_r_q;
    assign capture_busy            = busy_q;
    assign capture_done            = done_q;
    assign frame_wr_en             = fwe_q;
    assign frame_wr_addr           = fwaddr_q;
    assign frame_wr_data           = fwdata_q;
    assign drop_count              = drop_q;
`ifdef AUDIO_SEQ_PEAK_EN
    assign peak_level              = peak_q;
`endif

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Self-checking bench for audio_frame_sequencer: transaction-level model compared every
// cycle, plus directed literal checks for transfer, drop, gating, capture and reset.
module tb_audio_frame_sequencer;

    localparam int FRAME_LEN = 256;
    localparam int ADDR_W    = 8;
    localparam int STALL_MAX = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetn;
    logic              avail, allowed, cs;
    logic [31:0]       lin, rin;
    logic [17:0]       gp;
    logic              read_audio_in, write_audio_out, capture_busy, capture_done, frame_wr_en;
    logic [31:0]       lout, rout;
    logic [ADDR_W-1:0] frame_wr_addr;
    logic [15:0]       frame_wr_data;
    logic [7:0]        drop_count;
`ifdef AUDIO_SEQ_PEAK_EN
    logic [15:0]       peak_level;
`endif

    audio_frame_sequencer #(.FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W), .STALL_MAX(STALL_MAX)) dut (
        .CLOCK_50               (clk),
        .resetn                 (resetn),
        .audio_in_available     (avail),
        .left_channel_audio_in  (lin),
        .right_channel_audio_in (rin),
        .read_audio_in          (read_audio_in),
        .audio_out_allowed      (allowed),
        .left_channel_audio_out (lout),
        .right_channel_audio_out(rout),
        .write_audio_out        (write_audio_out),
        .gate_period            (gp),
        .capture_start          (cs),
        .capture_busy           (capture_busy),
        .capture_done           (capture_done),
        .frame_wr_en            (frame_wr_en),
        .frame_wr_addr          (frame_wr_addr),
        .frame_wr_data          (frame_wr_data),
        .drop_count             (drop_count)
`ifdef AUDIO_SEQ_PEAK_EN
        ,
        .peak_level             (peak_level)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_mono(input logic [15:0] l, input logic [15:0] r);
        int s;
        s = int'($signed(l)) + int'($signed(r));
        s = s >>> 1;
        return s[15:0];
    endfunction

    function automatic int ref_abs(input logic [15:0] v);
        int a;
        a = int'($signed(v));
        if (a < 0) a = -a;
        if (a > 32767) a = 32767;
        return a;
    endfunction

    // Model state: sequencer availability as a cooldown, capture as a sample count.
    int              m_cool = 0, m_stall = 0, m_gcnt = 0, m_capn = 0, m_peak = 0;
    bit              m_mute = 0, m_busy = 0, m_isx = 0, m_dpend = 0;
    logic [15:0]     m_latl = '0, m_latr = '0;
    logic            e_read = 0, e_write = 0, e_fwe = 0, e_done = 0, e_busy = 0;
    logic [31:0]     e_dl = '0, e_dr = '0;
    logic [ADDR_W-1:0] e_faddr = '0;
    logic [15:0]     e_fdata = '0;
    logic [7:0]      e_drop = '0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_cool = 0; m_stall = 0; m_gcnt = 0; m_capn = 0; m_peak = 0;
            m_mute = 0; m_busy = 0; m_isx = 0; m_dpend = 0;
            m_latl = '0; m_latr = '0;
            e_read = 0; e_write = 0; e_fwe = 0; e_done = 0; e_busy = 0;
            e_dl = '0; e_dr = '0; e_faddr = '0; e_fdata = '0; e_drop = '0;
        end else begin : step
            bit n_read, n_write, n_fwe, n_done, n_isx, n_busy, n_dpend;
            n_read = 0; n_write = 0; n_fwe = 0; n_done = 0; n_isx = 0; n_dpend = 0;
            n_busy = m_busy;

            if (m_isx && m_busy) begin
                n_fwe   = 1;
                e_faddr = ADDR_W'(m_capn);
                e_fdata = ref_mono(m_latl, m_latr);
                if (ref_abs(m_latl) > m_peak) m_peak = ref_abs(m_latl);
                m_capn++;
                if (m_capn == FRAME_LEN) begin
                    n_dpend = 1;
                    m_capn  = 0;
                end
            end
            if (m_dpend) begin
                n_done  = 1;
                n_busy  = 0;
                e_faddr = '0;
            end
            if (cs && !m_busy) begin
                n_busy = 1;
                m_capn = 0;
                m_peak = 0;
            end

            if (m_cool == 0) begin
                if (avail && allowed) begin
                    n_read = 1; n_write = 1; n_isx = 1;
                    e_dl = m_mute ? 32'd0 : lin;
                    e_dr = m_mute ? 32'd0 : rin;
                    m_latl = lin[31:16];
                    m_latr = rin[31:16];
                    m_cool = 2; m_stall = 0;
                end else if (avail) begin
                    m_stall++;
                    if (m_stall == STALL_MAX) begin
                        n_read = 1;
                        if (e_drop != 8'hFF) e_drop = e_drop + 8'd1;
                        m_stall = 0; m_cool = 2;
                    end
                end else begin
                    m_stall = 0;
                end
            end else begin
                m_cool--;
            end

            if (gp == 0) begin
                m_mute = 0; m_gcnt = 0;
            end else if (m_gcnt >= int'(gp)) begin
                m_gcnt = 0; m_mute = !m_mute;
            end else begin
                m_gcnt++;
            end

            e_read = n_read; e_write = n_write; e_fwe = n_fwe; e_done = n_done;
            m_isx = n_isx; m_busy = n_busy; m_dpend = n_dpend; e_busy = n_busy;
        end
    end

    always @(negedge clk) begin
        chk("m_read",  32'(read_audio_in),   32'(e_read));
        chk("m_write", 32'(write_audio_out), 32'(e_write));
        chk("m_left",  lout,                 e_dl);
        chk("m_right", rout,                 e_dr);
        chk("m_fwe",   32'(frame_wr_en),     32'(e_fwe));
        chk("m_faddr", 32'(frame_wr_addr),   32'(e_faddr));
        chk("m_fdata", 32'(frame_wr_data),   32'(e_fdata));
        chk("m_done",  32'(capture_done),    32'(e_done));
        chk("m_busy",  32'(capture_busy),    32'(e_busy));
        chk("m_drop",  32'(drop_count),      32'(e_drop));
`ifdef AUDIO_SEQ_PEAK_EN
        chk("m_peak",  32'(peak_level),      32'(m_peak));
`endif
    end

    task automatic wait_read(input string nm, input int limit);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!read_audio_in && k < limit);
        chk(nm, 32'(read_audio_in), 32'(1));
    endtask

    initial begin : stim
        int k, zc, nzc, wcount, ncnt, since_last, dones;
        bit got_done, first;
        resetn = 1'b0; avail = 0; allowed = 0; cs = 0; lin = '0; rin = '0; gp = '0;
        repeat (3) @(negedge clk);
        chk("rst_read", 32'(read_audio_in), 32'(0));
        chk("rst_busy", 32'(capture_busy), 32'(0));
        chk("rst_drop", 32'(drop_count), 32'(0));
        resetn = 1'b1;
        @(negedge clk);

        // Basic transfer and throughput
        lin = 32'h1234_0000; rin = 32'h5678_0000; avail = 1; allowed = 1;
        wait_read("t1_read", 10);
        chk("t1_write", 32'(write_audio_out), 32'(1));
        chk("t1_left", lout, 32'h1234_0000);
        chk("t1_right", rout, 32'h5678_0000);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!read_audio_in && k < 20);
        chk("t1_gap", 32'(k), 32'(3));

        // Stall timeout and drop saturation
        allowed = 0;
        wait_read("t2_read", STALL_MAX + 10);
        chk("t2_nowrite", 32'(write_audio_out), 32'(0));
        chk("t2_drop1", 32'(drop_count), 32'(1));
        repeat (3050) @(negedge clk);
        chk("t2_sat", 32'(drop_count), 32'(255));

        // Mute gating
        allowed = 1; lin = 32'h0001_0002; rin = 32'h0003_0004; gp = 18'd10;
        zc = 0; nzc = 0;
        repeat (90) begin
            @(negedge clk);
            if (write_audio_out) begin
                if (lout == 0) zc++; else nzc++;
            end
        end
        chk("t3_muted_seen", 32'(zc > 0), 32'(1));
        chk("t3_open_seen", 32'(nzc > 0), 32'(1));
        gp = 18'd0;
        repeat (2) @(negedge clk);
        zc = 0;
        repeat (15) begin
            @(negedge clk);
            if (write_audio_out && lout == 0) zc++;
        end
        chk("t3_unmuted", 32'(zc), 32'(0));

        // Full frame capture with an ignored second start
        avail = 0; lin = '0; rin = '0;
        repeat (4) @(negedge clk);
        cs = 1;
        @(negedge clk);
        cs = 0; avail = 1; allowed = 1;
        wcount = 0; ncnt = 0; since_last = -1; got_done = 0;
        for (int i = 0; i < 2000 && !got_done; i++) begin
            @(negedge clk);
            cs = 0;
            if (since_last >= 0) since_last++;
            if (frame_wr_en) begin
                chk("t4_addr", 32'(frame_wr_addr), 32'(wcount));
                chk("t4_data", 32'(frame_wr_data), 32'(wcount));
                if (frame_wr_addr == 8'd255) since_last = 0;
                wcount++;
                if (wcount == 50) cs = 1;
            end
            if (read_audio_in) begin
                ncnt++;
                lin = {ncnt[15:0], 16'h0000};
                rin = lin;
            end
            if (capture_done) begin
                got_done = 1;
                chk("t4_done_lat", 32'(since_last), 32'(1));
                chk("t4_busy_low", 32'(capture_busy), 32'(0));
                chk("t4_count", 32'(wcount), 32'(256));
            end
        end
        chk("t4_done_seen", 32'(got_done), 32'(1));

        // Extreme mono mix, then reset in the middle of a frame
        avail = 0; lin = 32'h8000_0000; rin = 32'h7FFF_0000;
        repeat (4) @(negedge clk);
        cs = 1;
        @(negedge clk);
        cs = 0; avail = 1;
        first = 1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (frame_wr_en && first) begin
                first = 0;
                chk("t5_data", 32'(frame_wr_data), 32'h0000_FFFF);
`ifdef AUDIO_SEQ_PEAK_EN
                chk("t5_peak", 32'(peak_level), 32'(32767));
`endif
            end
            if (frame_wr_en && frame_wr_addr == 8'd100) break;
        end
        chk("t6_at100", 32'(frame_wr_addr), 32'(100));
        #2 resetn = 1'b0;
        #1;
        chk("t6_read", 32'(read_audio_in), 32'(0));
        chk("t6_write", 32'(write_audio_out), 32'(0));
        chk("t6_left", lout, 32'h0);
        chk("t6_right", rout, 32'h0);
        chk("t6_fwe", 32'(frame_wr_en), 32'(0));
        chk("t6_faddr", 32'(frame_wr_addr), 32'(0));
        chk("t6_fdata", 32'(frame_wr_data), 32'(0));
        chk("t6_busy", 32'(capture_busy), 32'(0));
        chk("t6_drop", 32'(drop_count), 32'(0));
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (capture_done) dones++;
        end
        chk("t6_nodone", 32'(dones), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
